// File: rtl/gray_updown.sv
// gray_updown: up/down counter that presents the count as both a binary and a
// Gray-coded value, with sticky overflow/underflow flags and a one-cycle wrap pulse.
//
// Parameters
//   WIDTH      counter width in bits (2..16)
//   INIT       binary count loaded while reset is asserted (must be < 2**WIDTH)
//
// Ports
//   Clk        rising-edge clock for all state
//   Reset      asynchronous, active-low reset
//   En         count enable
//   Up         direction: 1 = increment, 0 = decrement
//   Load       synchronous load strobe (has priority over En)
//   LoadValue  binary value taken on Load
//   Clr        synchronous clear of the sticky flags (a same-edge event wins)
//   Output     registered Gray code of the count
//   Count      registered binary count
//   Overflow   sticky: an up-count passed the maximum
//   Underflow  sticky: a down-count passed zero
//   Wrap       one-cycle pulse after an overflow or underflow event
//
// Configuration
//   GRAY_SATURATE_EN  when defined, the count clamps at the boundary instead of
//                     wrapping; flags and Wrap behave identically in both modes.

module gray_updown #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned INIT  = 0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Up,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadValue,
    input  logic             Clr,
    output logic [WIDTH-1:0] Output,
    output logic [WIDTH-1:0] Count,
    output logic             Overflow,
    output logic             Underflow,
    output logic             Wrap
);

`ifdef GRAY_SATURATE_EN
    localparam bit SATURATE = 1'b1;
`else
    localparam bit SATURATE = 1'b0;
`endif

    localparam logic [WIDTH-1:0] INIT_BIN  = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] INIT_GRAY = INIT_BIN ^ (INIT_BIN >> 1);
    localparam logic [WIDTH-1:0] MAX_BIN   = {WIDTH{1'b1}};

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] gray_q,  gray_d;
    logic             ovf_q,   ovf_d;
    logic             unf_q,   unf_d;
    logic             wrap_q,  wrap_d;

    logic             step_up;
    logic             step_dn;
    logic             ovf_event;
    logic             unf_event;

    // Next-state logic. Load masks the count step entirely, so a load can never
    // raise an event, touch the flags (other than via Clr) or produce Wrap.
    always_comb begin
        step_up   = ~Load & En & Up;
        step_dn   = ~Load & En & ~Up;
        ovf_event = step_up & (count_q == MAX_BIN);
        unf_event = step_dn & (count_q == '0);

        count_d = count_q;
        if (Load) begin
            count_d = LoadValue;
        end else if (SATURATE && (ovf_event || unf_event)) begin
            count_d = count_q;
        end else if (step_up) begin
            count_d = count_q + 1'b1;
        end else if (step_dn) begin
            count_d = count_q - 1'b1;
        end

        // Gray is derived from the next binary value so both registers always
        // describe the same count, with no input-to-output combinational path.
        gray_d = count_d ^ (count_d >> 1);

        // Clear first, then let a same-edge event set the flag again.
        ovf_d  = ovf_event | (ovf_q & ~Clr);
        unf_d  = unf_event | (unf_q & ~Clr);
        wrap_d = ovf_event | unf_event;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            count_q <= INIT_BIN;
            gray_q  <= INIT_GRAY;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            gray_q  <= gray_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            wrap_q  <= wrap_d;
        end
    end

    assign Count     = count_q;
    assign Output    = gray_q;
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;
    assign Wrap      = wrap_q;

endmodule

// File: tb/tb_gray_updown.sv
module tb_gray_updown;

    localparam int W   = 3;
    localparam int MOD = 1 << W;
`ifdef GRAY_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         Clk       = 1'b0;
    logic         Reset     = 1'b0;
    logic         En        = 1'b0;
    logic         Up        = 1'b0;
    logic         Load      = 1'b0;
    logic [W-1:0] LoadValue = '0;
    logic         Clr       = 1'b0;
    logic [W-1:0] Output;
    logic [W-1:0] Count;
    logic         Overflow;
    logic         Underflow;
    logic         Wrap;

    gray_updown #(
        .WIDTH (W),
        .INIT  (0)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .En        (En),
        .Up        (Up),
        .Load      (Load),
        .LoadValue (LoadValue),
        .Clr       (Clr),
        .Output    (Output),
        .Count     (Count),
        .Overflow  (Overflow),
        .Underflow (Underflow),
        .Wrap      (Wrap)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    // 3-bit reflected Gray sequence, indexed by binary count.
    int gray_tab [8] = '{0, 1, 3, 2, 6, 7, 5, 4};

    typedef struct {
        bit       load;
        int       lv;
        bit       en;
        bit       up;
        bit       clr;
        int       cnt;
        bit       ovf;
        bit       unf;
        bit       wrap;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit load, input int lv, input bit en, input bit up, input bit clr,
                       input int cnt, input bit ovf, input bit unf, input bit wrap);
        vec_t v;
        v.load = load; v.lv = lv; v.en = en; v.up = up; v.clr = clr;
        v.cnt = cnt; v.ovf = ovf; v.unf = unf; v.wrap = wrap;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int cnt, input bit ovf, input bit unf,
                         input bit wrap);
        logic [W-1:0] ecnt;
        logic [W-1:0] egray;
        ecnt  = W'(cnt);
        egray = W'(gray_tab[cnt]);
        total++;
        if (Count !== ecnt || Output !== egray || Overflow !== ovf || Underflow !== unf ||
            Wrap !== wrap) begin
            bad++;
            $display("FAIL %s: got cnt=%0d out=%b ovf=%b unf=%b wrap=%b, want cnt=%0d out=%b ovf=%b unf=%b wrap=%b",
                     name, Count, Output, Overflow, Underflow, Wrap,
                     ecnt, egray, ovf, unf, wrap);
        end
    endtask

    task automatic drive(input bit load, input int lv, input bit en, input bit up, input bit clr);
        Load = load; LoadValue = W'(lv); En = en; Up = up; Clr = clr;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c8;
        int c10;
        int m_cnt;
        bit m_ovf, m_unf, m_wrap;
        logic [W-1:0] prev_out;

        c8  = SAT ? 7 : 0;
        c10 = SAT ? 0 : 7;

        // Up-count through the boundary, then underflow, load priority, set-wins clear.
        for (int i = 1; i <= 7; i++) add(0, 0, 1, 1, 0, i, 0, 0, 0);
        add(0, 0, 1, 1, 0, c8, 1, 0, 1);
        add(1, 0, 1, 1, 0, 0, 1, 0, 0);
        add(0, 0, 1, 0, 0, c10, 1, 1, 1);
        add(0, 0, 0, 0, 0, c10, 1, 1, 0);
        add(0, 0, 0, 0, 1, c10, 0, 0, 0);
        add(1, 5, 1, 1, 0, 5, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 0, 5, 0, 0, 0);
        add(1, 7, 0, 0, 0, 7, 0, 0, 0);
        add(0, 0, 1, 1, 1, c8, 1, 0, 1);
        add(0, 0, 0, 0, 1, c8, 0, 0, 0);
        add(1, 7, 0, 0, 0, 7, 0, 0, 0);
        add(0, 0, 1, 1, 0, c8, 1, 0, 1);
        add(0, 0, 1, 1, 0, SAT ? 7 : 1, 1, 0, SAT ? 1 : 0);

        #12;
        check("reset_state", 0, 0, 0, 0);
        @(negedge Clk);
        Reset = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].load, vecs[i].lv, vecs[i].en, vecs[i].up, vecs[i].clr);
            tick();
            check($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ovf, vecs[i].unf, vecs[i].wrap);
        end

        // Asynchronous reset mid-count with a flag set.
        drive(1, 7, 0, 0, 1);
        tick();
        drive(0, 0, 1, 1, 0);
        tick();
        drive(1, 3, 0, 0, 0);
        tick();
        check("pre_async_rst", 3, 1, 0, 0);
        drive(0, 0, 1, 1, 0);
        #2;
        Reset = 1'b0;
        #1;
        check("async_rst", 0, 0, 0, 0);
        tick();
        check("rst_held", 0, 0, 0, 0);
        @(negedge Clk);
        Reset = 1'b1;
        tick();
        check("first_edge", 1, 0, 0, 0);

        // Randomized run against the arithmetic model.
        @(negedge Clk);
        Reset = 1'b0;
        drive(0, 0, 0, 0, 0);
        @(negedge Clk);
        Reset = 1'b1;
        m_cnt = 0; m_ovf = 0; m_unf = 0; m_wrap = 0;
        for (int n = 0; n < 600; n++) begin
            bit ld, en, up, clr, ev_o, ev_u;
            int lv, nxt;
            ld  = ($urandom_range(0, 15) == 0);
            lv  = int'($urandom_range(0, MOD - 1));
            en  = ($urandom_range(0, 3) != 0);
            up  = ($urandom_range(0, 2) != 0) ^ (n >= 300);
            clr = ($urandom_range(0, 7) == 0);
            drive(ld, lv, en, up, clr);

            ev_o = 0; ev_u = 0; nxt = m_cnt;
            if (ld) begin
                nxt = lv;
            end else if (en && up) begin
                ev_o = (m_cnt + 1 >= MOD);
                nxt  = (ev_o && SAT) ? MOD - 1 : (m_cnt + 1) % MOD;
            end else if (en) begin
                ev_u = (m_cnt - 1 < 0);
                nxt  = (ev_u && SAT) ? 0 : (m_cnt - 1 + MOD) % MOD;
            end
            if (clr) begin
                m_ovf = 0;
                m_unf = 0;
            end
            if (ev_o) m_ovf = 1;
            if (ev_u) m_unf = 1;
            m_wrap = ev_o | ev_u;

            prev_out = Output;
            tick();
            check("rand", nxt, m_ovf, m_unf, m_wrap);
            if (!ld && nxt != m_cnt) begin
                total++;
                if ($countones(prev_out ^ Output) != 1) begin
                    bad++;
                    $display("FAIL gray_step: got %b -> %b, want exactly one bit change",
                             prev_out, Output);
                end
            end
            m_cnt = nxt;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gray_updown.md
GRAY_UPDOWN -- requirements
Module: gray_updown

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, giving the counter width in bits (legal range 2..16).
REQ-002 The block SHALL have parameter INIT, default 0, giving the binary count value loaded at reset (must be < 2^WIDTH).
REQ-003 The block SHALL have port Clk  input  1  single rising-edge clock for all state.
REQ-004 The block SHALL have port Reset  input  1  asynchronous, active-low reset (low = reset asserted).
REQ-005 The block SHALL have port En  input  1  count enable, sampled on Clk rising edge.
REQ-006 The block SHALL have port Up  input  1  direction, 1 = increment, 0 = decrement.
REQ-007 The block SHALL have port Load  input  1  synchronous load strobe.
REQ-008 The block SHALL have port LoadValue  input  WIDTH  binary value taken on Load.
REQ-009 The block SHALL have port Clr  input  1  synchronous clear of the sticky flags.
REQ-010 The block SHALL have port Output  output  WIDTH  registered Gray code of the current count.
REQ-011 The block SHALL have port Count  output  WIDTH  registered binary of the current count.
REQ-012 The block SHALL have port Overflow  output  1  sticky flag, an up-count passed max.
REQ-013 The block SHALL have port Underflow  output  1  sticky flag, a down-count passed 0.
REQ-014 The block SHALL have port Wrap  output  1  one-cycle pulse marking a boundary crossing.

Function
REQ-015 Output SHALL always equal Count ^ (Count >> 1); both are registered, with no combinational path from inputs.
REQ-016 Per rising edge, priority SHALL be: Load > En; Load=1 sets Count=LoadValue irrespective of En/Up.
REQ-017 With Load=0, En=1, Up=1, Count SHALL become Count+1 in the next cycle; with Up=0, Count-1; En=0 holds Count.
REQ-018 An up-count from 2^WIDTH-1 SHALL be an overflow event; a down-count from 0 SHALL be an underflow event.
REQ-019 On an overflow event, Overflow SHALL be 1 from the next cycle and stay 1 until Clr or reset; Underflow likewise.
REQ-020 Wrap SHALL be 1 for exactly the one cycle following an overflow or underflow event, else 0.
REQ-021 Clr=1 SHALL zero Overflow and Underflow next cycle unless an event occurs the same edge, in which case that flag is set (set wins).
REQ-022 Load SHALL NOT alter Overflow/Underflow and SHALL NOT itself generate Wrap.
REQ-023 Each step SHALL change exactly one bit of Output, including across the boundary.

Reset
REQ-024 While Reset=0, Count SHALL be INIT, Output SHALL be INIT^(INIT>>1), and Overflow, Underflow and Wrap SHALL be 0, asynchronously.
REQ-025 Reset asserted mid-count SHALL take effect immediately; the first edge after Reset rises SHALL act on state INIT.

Configuration
REQ-026 With macro GRAY_SATURATE_EN defined, the counter SHALL saturate: an overflow event holds Count at 2^WIDTH-1 and an underflow event holds it at 0, while flags and Wrap still assert per REQ-019/020.
REQ-027 Without GRAY_SATURATE_EN, the counter SHALL wrap modulo 2^WIDTH (max+1 -> 0, 0-1 -> max).

Verification
REQ-028 WIDTH=3, reset then En=1, Up=1 for 8 edges -> Output 001,011,010,110,111,101,100,000; Wrap pulses once on the eighth; Overflow=1 thereafter.
REQ-029 From Count=0, Up=0, En=1 for 1 edge -> Count=7, Output=100, Underflow=1, Wrap=1 for one cycle; Overflow unchanged.
REQ-030 Load=1, LoadValue=5, En=1 the same edge -> Count=5, Output=111, no Wrap; then En=0 for 3 edges -> Count holds 5.
REQ-031 Count=7, Up=1, En=1, Clr=1 the same edge -> Overflow=1 (set wins); a following Clr alone -> Overflow=0.
REQ-032 Reset low asynchronously mid-count at Count=3 -> Count=INIT, all flags 0 before the next Clk edge.
REQ-033 GRAY_SATURATE_EN defined, Count=7, Up=1, En=1 for 2 edges -> Count stays 7, Overflow=1, Wrap pulses each edge.
